// File: rtl/configuration_timer_pkg.sv
// Shared definitions for the configuration timer scheduler.
//   - register addresses and control bits of the interval timer s1 slave
//   - register offsets of the scheduler's CPU-visible slave
//   - master FSM state encoding
package configuration_timer_pkg;

   // Interval timer s1 register addresses
   localparam logic [2:0] TMR_REG_STATUS  = 3'd0;
   localparam logic [2:0] TMR_REG_CONTROL = 3'd1;

   // Interval timer CONTROL register bits
   localparam logic [15:0] TMR_CTRL_ITO   = 16'h0001;
   localparam logic [15:0] TMR_CTRL_CONT  = 16'h0002;
   localparam logic [15:0] TMR_CTRL_START = 16'h0004;
   localparam logic [15:0] TMR_CTRL_STOP  = 16'h0008;

   // Scheduler CPU register offsets
   localparam logic [2:0] REG_STATUS = 3'd0;
   localparam logic [2:0] REG_CTRL   = 3'd1;
   localparam logic [2:0] REG_MASK   = 3'd2;
   localparam logic [2:0] REG_MODE   = 3'd3;
   localparam logic [2:0] REG_COUNT0 = 3'd4;

   // Timer master FSM states
   typedef enum logic [2:0] {
      S_START,
      S_IDLE,
      S_ACK,
      S_WAIT,
      S_TICK,
      S_STOP,
      S_HALT
   } state_e;

endpackage

// File: rtl/configuration_timer_scheduler_if.sv
// Bus bundle of the configuration timer scheduler.
//   CPU side (Avalon-MM slave, no wait states):
//     address, chipselect, write_n, writedata -> scheduler
//     readdata (registered), irq              <- scheduler
//   Timer side (Avalon-MM master towards the timer s1 slave):
//     tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata <- scheduler
//     tmr_irq                                                  -> scheduler
//   state: current master FSM state, for observation only.
//
// Handshake: a transfer happens in every cycle where chipselect is high;
// write_n low marks it as a write, write_n high as a read. There is no
// wait-request, so both sides complete the transfer in that same cycle.
//
// Modports: slave = the scheduler, master = the CPU/timer environment.
interface configuration_timer_scheduler_if;

   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic        irq;

   logic [2:0]  tmr_address;
   logic        tmr_chipselect;
   logic        tmr_write_n;
   logic [15:0] tmr_writedata;
   logic        tmr_irq;

   configuration_timer_pkg::state_e state;

   modport slave (
      input  address, chipselect, write_n, writedata, tmr_irq,
      output readdata, irq, tmr_address, tmr_chipselect, tmr_write_n,
             tmr_writedata, state
   );

   modport master (
      output address, chipselect, write_n, writedata, tmr_irq,
      input  readdata, irq, tmr_address, tmr_chipselect, tmr_write_n,
             tmr_writedata, state
   );

endinterface

// File: rtl/configuration_timer_channel.sv
// One software countdown channel.
//   load/load_value : CPU write of the channel COUNT register
//   tick            : one timer timeout, decrements an active channel
//   periodic        : reload on expiry instead of going inactive
//   count           : current count
//   expire          : one-cycle pulse when the channel expires on this tick
module configuration_timer_channel #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             tick,
   input  logic             periodic,
   output logic [CNT_W-1:0] count,
   output logic             expire
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] reload_q;
   logic             active_q;
   logic             at_one;

   assign at_one = active_q && (count_q == CNT_W'(1));
   // A load in the tick cycle replaces the tick for this channel.
   assign expire = tick && !load && at_one;
   assign count  = count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q  <= '0;
         reload_q <= '0;
         active_q <= 1'b0;
      end else if (load) begin
         count_q  <= load_value;
         reload_q <= load_value;
         active_q <= (load_value != '0);
      end else if (tick && active_q) begin
         if (count_q > CNT_W'(1)) begin
            count_q <= count_q - CNT_W'(1);
         end else if (at_one) begin
            if (periodic) begin
               count_q <= reload_q;
            end else begin
               count_q  <= '0;
               active_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/configuration_timer_scheduler.sv
// Multiplexes the hardware interval timer into NUM_CH countdown channels.
//   clk, reset_n : system clock, asynchronous active-low reset
//   bus (slave)  : CPU register slave, timer master port, irq, FSM state
// The FSM programs the timer into continuous interrupt mode, acknowledges
// every timeout and turns each one into a tick for all active channels.
module configuration_timer_scheduler
   import configuration_timer_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   configuration_timer_scheduler_if.slave bus
);

   logic              cpu_wr;
   logic              cpu_rd;
   logic              run_q;
   logic              irq_en_q;
   logic [NUM_CH-1:0] mask_q;
   logic [NUM_CH-1:0] mode_q;
   logic [NUM_CH-1:0] expired_q;
   logic [NUM_CH-1:0] w1c;
   logic [NUM_CH-1:0] load;
   logic [NUM_CH-1:0] expire;
   logic [CNT_W-1:0]  count [NUM_CH];
   logic [15:0]       rd_data;
   logic [15:0]       readdata_q;
   logic              tick;

   state_e            state_q;
   state_e            state_d;
   logic              tmr_cs;
   logic [2:0]        tmr_addr;
   logic [15:0]       tmr_wdata;

   assign cpu_wr = bus.chipselect && !bus.write_n;
   assign cpu_rd = bus.chipselect && bus.write_n;
   assign w1c    = (cpu_wr && bus.address == REG_STATUS) ?
                   bus.writedata[NUM_CH-1:0] : '0;

   // ---------------- channels ----------------
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign load[c] = cpu_wr && (bus.address == REG_COUNT0 + 3'(c));

      configuration_timer_channel #(.CNT_W(CNT_W)) u_ch (
         .clk        (clk),
         .reset_n    (reset_n),
         .load       (load[c]),
         .load_value (bus.writedata[CNT_W-1:0]),
         .tick       (tick),
         .periodic   (mode_q[c]),
         .count      (count[c]),
         .expire     (expire[c])
      );
   end

   // ---------------- CPU registers ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run_q     <= 1'b1;
         irq_en_q  <= 1'b0;
         mask_q    <= '0;
         mode_q    <= '0;
         expired_q <= '0;
      end else begin
         if (cpu_wr) begin
            case (bus.address)
               REG_CTRL: begin
                  run_q    <= bus.writedata[0];
                  irq_en_q <= bus.writedata[1];
               end
               REG_MASK: mask_q <= bus.writedata[NUM_CH-1:0];
               REG_MODE: mode_q <= bus.writedata[NUM_CH-1:0];
               default:  ;
            endcase
         end
         // Clear first, then set: an expiry in the same cycle survives.
         expired_q <= (expired_q & ~w1c) | expire;
      end
   end

   always_comb begin
      rd_data = '0;
      case (bus.address)
         REG_STATUS: rd_data = 16'(expired_q);
         REG_CTRL:   rd_data = {14'd0, irq_en_q, run_q};
         REG_MASK:   rd_data = 16'(mask_q);
         REG_MODE:   rd_data = 16'(mode_q);
         default: begin
            for (int c = 0; c < NUM_CH; c++) begin
               if (bus.address == REG_COUNT0 + 3'(c)) rd_data = 16'(count[c]);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata_q <= '0;
      end else if (cpu_rd) begin
         readdata_q <= rd_data;
      end
   end

   assign bus.readdata = readdata_q;
   assign bus.irq      = irq_en_q && |(expired_q & mask_q);

   // ---------------- timer master FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_START;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      tmr_cs    = 1'b0;
      tmr_addr  = '0;
      tmr_wdata = '0;
      tick      = 1'b0;
      case (state_q)
         S_START: begin
            tmr_cs    = 1'b1;
            tmr_addr  = TMR_REG_CONTROL;
            tmr_wdata = TMR_CTRL_START | TMR_CTRL_CONT | TMR_CTRL_ITO;
            state_d   = S_IDLE;
         end
         S_IDLE: begin
            if (!run_q)           state_d = S_STOP;
            else if (bus.tmr_irq) state_d = S_ACK;
         end
         S_ACK: begin
            tmr_cs    = 1'b1;
            tmr_addr  = TMR_REG_STATUS;
            tmr_wdata = '0;
            state_d   = S_WAIT;
         end
         // Gives the timer a cycle to drop its irq before we look again.
         S_WAIT: state_d = S_TICK;
         S_TICK: begin
            tick    = 1'b1;
            state_d = S_IDLE;
         end
         S_STOP: begin
            tmr_cs    = 1'b1;
            tmr_addr  = TMR_REG_CONTROL;
            tmr_wdata = TMR_CTRL_STOP;
            state_d   = S_HALT;
         end
         S_HALT: begin
            if (run_q) state_d = S_START;
         end
         default: state_d = S_START;
      endcase
   end

   // The reset state is S_START, which is a write state; gating with
   // reset_n keeps the bus idle while reset is held and drops an in-flight
   // write the moment reset asserts.
   assign bus.tmr_chipselect = tmr_cs && reset_n;
   assign bus.tmr_write_n    = !(tmr_cs && reset_n);
   assign bus.tmr_address    = reset_n ? tmr_addr : '0;
   assign bus.tmr_writedata  = reset_n ? tmr_wdata : '0;
   assign bus.state          = state_q;

endmodule

// File: tb/tb_configuration_timer_scheduler.sv
module tb_configuration_timer_scheduler;
   import configuration_timer_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;

   // expected timer writes, {address, data}
   logic [18:0] exp_q[$];

   // reference model state
   int          m_cnt [4];
   int          m_rel [4];
   bit          m_act [4];
   logic [3:0]  m_exp, m_mask, m_mode;
   logic        m_run, m_ien;

   configuration_timer_scheduler_if bus();

   configuration_timer_scheduler #(.NUM_CH(4), .CNT_W(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   // ---------------- timer-bus scoreboard ----------------
   always @(negedge clk) begin : mon
      logic [18:0] e;
      if (reset_n === 1'b1 && bus.tmr_chipselect === 1'b1 && bus.tmr_write_n === 1'b0) begin
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL tmr_write_unexpected: got addr=%0d data=%h, required no write",
                     bus.tmr_address, bus.tmr_writedata);
         end else begin
            e = exp_q.pop_front();
            if ({bus.tmr_address, bus.tmr_writedata} !== e)
               $display("FAIL tmr_write: got addr=%0d data=%h, required addr=%0d data=%h",
                        bus.tmr_address, bus.tmr_writedata, e[18:16], e[15:0]);
            else n_pass++;
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         m_cnt[i] = 0; m_rel[i] = 0; m_act[i] = 0;
      end
      m_exp = 0; m_mask = 0; m_mode = 0; m_run = 1; m_ien = 0;
   endfunction

   function automatic void model_write(input logic [2:0] a, input logic [15:0] d);
      case (a)
         3'd0: m_exp = m_exp & ~d[3:0];
         3'd1: begin m_run = d[0]; m_ien = d[1]; end
         3'd2: m_mask = d[3:0];
         3'd3: m_mode = d[3:0];
         default: begin
            m_cnt[a[1:0]] = int'(d);
            m_rel[a[1:0]] = int'(d);
            m_act[a[1:0]] = (d != 0);
         end
      endcase
   endfunction

   function automatic void model_tick(input logic [3:0] skip);
      for (int i = 0; i < 4; i++) begin
         if (m_act[i] && !skip[i]) begin
            if (m_cnt[i] > 1) m_cnt[i]--;
            else if (m_cnt[i] == 1) begin
               m_exp[i] = 1'b1;
               if (m_mode[i]) m_cnt[i] = m_rel[i];
               else begin m_cnt[i] = 0; m_act[i] = 0; end
            end
         end
      end
   endfunction

   function automatic logic [15:0] model_read(input logic [2:0] a);
      case (a)
         3'd0: return {12'd0, m_exp};
         3'd1: return {14'd0, m_ien, m_run};
         3'd2: return {12'd0, m_mask};
         3'd3: return {12'd0, m_mode};
         default: return 16'(m_cnt[a[1:0]]);
      endcase
   endfunction

   function automatic logic model_irq();
      return m_ien && ((m_exp & m_mask) != 4'd0);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
      bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
      @(negedge clk);
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
      model_write(a, d);
   endtask

   task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
      bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = a;
      @(negedge clk);
      bus.chipselect = 1'b0;
      d = bus.readdata;
   endtask

   task automatic release_reset();
      model_reset();
      exp_q.push_back({3'd1, 16'h0007});
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
   endtask

   // One timer timeout; optionally a CPU write lands in the tick cycle.
   task automatic do_tick(input bit wr, input logic [2:0] a, input logic [15:0] d);
      logic [3:0] skip;
      exp_q.push_back({3'd0, 16'h0000});
      bus.tmr_irq = 1'b1;
      @(negedge clk);
      n_total++;
      if (bus.tmr_chipselect !== 1'b1 || bus.tmr_address !== 3'd0 || bus.tmr_writedata !== 16'h0)
         $display("FAIL ack_write: got cs=%b addr=%0d data=%h, required cs=1 addr=0 data=0000",
                  bus.tmr_chipselect, bus.tmr_address, bus.tmr_writedata);
      else n_pass++;
      bus.tmr_irq = 1'b0;
      @(negedge clk);
      @(negedge clk);
      skip = 4'd0;
      if (wr) begin
         bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
         model_write(a, d);
         if (a >= 3'd4) skip[a[1:0]] = 1'b1;
      end
      model_tick(skip);
      @(negedge clk);
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
      n_total++;
      if (bus.irq !== model_irq())
         $display("FAIL irq_after_tick: got %b, required %b", bus.irq, model_irq());
      else n_pass++;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [15:0] rd;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      n_total++;
      if (bus.readdata !== 16'h0 || bus.irq !== 1'b0)
         $display("FAIL reset_cpu_outputs: got readdata=%h irq=%b, required 0000 0", bus.readdata, bus.irq);
      else n_pass++;
      n_total++;
      if (bus.tmr_chipselect !== 1'b0 || bus.tmr_write_n !== 1'b1 || bus.tmr_address !== 3'd0 || bus.tmr_writedata !== 16'h0)
         $display("FAIL reset_tmr_idle: got cs=%b wn=%b addr=%0d data=%h, required 0 1 0 0000",
                  bus.tmr_chipselect, bus.tmr_write_n, bus.tmr_address, bus.tmr_writedata);
      else n_pass++;
      release_reset();
      repeat (2) @(negedge clk);
      n_total++;
      if (exp_q.size() != 0) $display("FAIL start_write: got %0d pending, required 0", exp_q.size());
      else n_pass++;
      n_total++;
      if (bus.state !== S_IDLE) $display("FAIL start_idle: got state %0d, required S_IDLE", bus.state);
      else n_pass++;
      for (int a = 0; a < 8; a++) begin
         cpu_read(3'(a), rd);
         n_total++;
         if (rd !== ((a == 1) ? 16'h0001 : 16'h0000))
            $display("FAIL reset_reg%0d: got %h, required %h", a, rd, (a == 1) ? 16'h0001 : 16'h0000);
         else n_pass++;
      end
   endtask

   task automatic test_basic();
      logic [15:0] rd;
      cpu_write(3'd4, 16'd3);
      cpu_write(3'd2, 16'h1);
      cpu_write(3'd1, 16'h3);
      for (int i = 0; i < 3; i++) do_tick(1'b0, 3'd0, 16'h0);
      n_total++;
      if (bus.irq !== 1'b1) $display("FAIL basic_irq: got %b, required 1", bus.irq);
      else n_pass++;
      cpu_read(3'd0, rd);
      n_total++;
      if (rd !== 16'h0001) $display("FAIL basic_status: got %h, required 0001", rd);
      else n_pass++;
      cpu_read(3'd4, rd);
      n_total++;
      if (rd !== 16'h0000) $display("FAIL basic_count0: got %h, required 0000", rd);
      else n_pass++;
   endtask

   task automatic test_periodic();
      logic [15:0] rd;
      cpu_write(3'd0, 16'h000F);
      cpu_write(3'd3, 16'h0002);
      cpu_write(3'd5, 16'd2);
      for (int i = 1; i <= 5; i++) begin
         do_tick(1'b0, 3'd0, 16'h0);
         cpu_read(3'd0, rd);
         n_total++;
         if (rd[1] !== ((i == 2) || (i == 4)) || rd !== model_read(3'd0))
            $display("FAIL periodic_status_tick%0d: got %h, required %h", i, rd, model_read(3'd0));
         else n_pass++;
         if (rd[1]) cpu_write(3'd0, 16'h0002);
      end
      cpu_read(3'd5, rd);
      n_total++;
      if (rd !== 16'd1) $display("FAIL periodic_count1: got %h, required 0001", rd);
      else n_pass++;
   endtask

   task automatic test_w1c_collision();
      logic [15:0] rd;
      cpu_write(3'd4, 16'd1);
      do_tick(1'b1, 3'd0, 16'h0001);
      cpu_read(3'd0, rd);
      n_total++;
      if (rd[0] !== 1'b1 || rd !== model_read(3'd0))
         $display("FAIL w1c_collision: got %h, required %h with bit0 set", rd, model_read(3'd0));
      else n_pass++;
   endtask

   task automatic test_stop_restart();
      logic [15:0] rd;
      exp_q.push_back({3'd1, 16'h0008});
      cpu_write(3'd1, 16'h0000);
      repeat (4) @(negedge clk);
      n_total++;
      if (exp_q.size() != 0 || bus.state !== S_HALT)
         $display("FAIL stop_write: got %0d pending state %0d, required 0 pending S_HALT", exp_q.size(), bus.state);
      else n_pass++;
      bus.tmr_irq = 1'b1;
      repeat (3) @(negedge clk);
      bus.tmr_irq = 1'b0;
      cpu_read(3'd5, rd);
      n_total++;
      if (rd !== model_read(3'd5)) $display("FAIL halt_no_tick: got %h, required %h", rd, model_read(3'd5));
      else n_pass++;
      exp_q.push_back({3'd1, 16'h0007});
      cpu_write(3'd1, 16'h0001);
      repeat (3) @(negedge clk);
      n_total++;
      if (exp_q.size() != 0 || bus.state !== S_IDLE)
         $display("FAIL restart_write: got %0d pending state %0d, required 0 pending S_IDLE", exp_q.size(), bus.state);
      else n_pass++;
   endtask

   task automatic test_count_in_tick();
      logic [15:0] rd;
      cpu_write(3'd6, 16'd9);
      do_tick(1'b1, 3'd6, 16'd7);
      cpu_read(3'd6, rd);
      n_total++;
      if (rd !== 16'd7) $display("FAIL count_in_tick: got %h, required 0007", rd);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [15:0] rd;
      logic [2:0]  a;
      int          op, ch;
      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 5);
         ch = $urandom_range(0, 3);
         case (op)
            0: cpu_write(3'(4 + ch), 16'($urandom_range(0, 4)));
            1: cpu_write(3'd3, 16'($urandom_range(0, 15)));
            2: cpu_write(3'd2, 16'($urandom_range(0, 15)));
            3: cpu_write(3'd1, {14'd0, 1'($urandom_range(0, 1)), 1'b1});
            4: cpu_write(3'd0, 16'($urandom_range(0, 15)));
            default: begin
               if ($urandom_range(0, 1) == 1)
                  do_tick(1'b1, ($urandom_range(0, 1) == 1) ? 3'd0 : 3'(4 + ch),
                          16'($urandom_range(0, 4)));
               else
                  do_tick(1'b0, 3'd0, 16'h0);
            end
         endcase
         a = 3'($urandom_range(0, 7));
         cpu_read(a, rd);
         n_total++;
         if (rd !== model_read(a)) $display("FAIL random_read%0d addr%0d: got %h, required %h", i, a, rd, model_read(a));
         else n_pass++;
         n_total++;
         if (bus.irq !== model_irq()) $display("FAIL random_irq%0d: got %b, required %b", i, bus.irq, model_irq());
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_write();
      logic [15:0] rd;
      cpu_write(3'd0, 16'h000F);
      cpu_write(3'd2, 16'h0001);
      cpu_write(3'd1, 16'h0003);
      cpu_write(3'd4, 16'd1);
      do_tick(1'b0, 3'd0, 16'h0);
      cpu_read(3'd0, rd);
      exp_q.push_back({3'd0, 16'h0000});
      bus.tmr_irq = 1'b1;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      n_total++;
      if (bus.tmr_chipselect !== 1'b0 || bus.tmr_write_n !== 1'b1 || bus.tmr_address !== 3'd0 || bus.tmr_writedata !== 16'h0)
         $display("FAIL reset_drops_write: got cs=%b wn=%b addr=%0d data=%h, required 0 1 0 0000",
                  bus.tmr_chipselect, bus.tmr_write_n, bus.tmr_address, bus.tmr_writedata);
      else n_pass++;
      n_total++;
      if (bus.readdata !== 16'h0 || bus.irq !== 1'b0)
         $display("FAIL reset_mid_outputs: got readdata=%h irq=%b, required 0000 0", bus.readdata, bus.irq);
      else n_pass++;
      bus.tmr_irq = 1'b0;
      @(negedge clk);
      release_reset();
      repeat (2) @(negedge clk);
      n_total++;
      if (bus.state !== S_IDLE) $display("FAIL reset_restart: got state %0d, required S_IDLE", bus.state);
      else n_pass++;
   endtask

   // ---------------- sequence ----------------
   initial begin
      bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
      bus.writedata = 16'h0; bus.tmr_irq = 1'b0;
      model_reset();
      test_reset();
      test_basic();
      test_periodic();
      test_w1c_collision();
      test_stop_restart();
      test_count_in_tick();
      test_random();
      test_reset_mid_write();
      repeat (2) @(negedge clk);
      n_total++;
      if (exp_q.size() != 0) $display("FAIL tmr_queue_drained: got %0d pending, required 0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/configuration_timer_scheduler.md
# configuration_timer_scheduler

Multiplexes the single hardware interval timer into `NUM_CH` software-visible countdown channels. At reset it programs the timer over a private Avalon-MM master port into continuous, interrupt-enabled mode. It acknowledges every timer timeout and uses each timeout as a tick that decrements all active channels. It sits between the CPU data master (Avalon-MM slave side) and the timer's `s1` slave, and replaces the timer's IRQ with a per-channel maskable IRQ.

## Interface
- `NUM_CH`, 4: number of channels, 1..4.
- `CNT_W`, 16: channel counter width in ticks, ≤16.

- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 3: CPU slave word address.
- `chipselect` in 1: CPU slave select.
- `write_n` in 1: CPU write strobe, active low.
- `writedata` in 16: CPU write data.
- `readdata` out 16: CPU read data, registered.
- `irq` out 1: CPU interrupt.
- `tmr_address` out 3: timer slave address.
- `tmr_chipselect` out 1: timer select.
- `tmr_write_n` out 1: timer write strobe, active low.
- `tmr_writedata` out 16: timer write data.
- `tmr_irq` in 1: timer timeout interrupt.

## Operation
- CPU register map (no wait states):
  - 0 STATUS: expired[NUM_CH-1:0]. Write-1-to-clear.
  - 1 CTRL: bit0 run (reset 1), bit1 irq_en (reset 0).
  - 2 MASK: per-channel IRQ enable (reset 0).
  - 3 MODE: per-channel periodic bit (reset 0).
  - 4+ch COUNT: write loads reload[ch] and count[ch], and sets active[ch] iff data≠0. Read returns count[ch]. Addresses ≥4+NUM_CH read 0 and ignore writes.
- Master FSM:
  - S_START: one-cycle write, `tmr_address`=1, data 0x0007 (START|CONT|ITO). Next: S_IDLE.
  - S_IDLE:
    - run=0 → S_STOP.
    - else `tmr_irq`=1 → S_ACK.
  - S_ACK: one-cycle write, `tmr_address`=0, data 0 (clears timeout). Next: S_WAIT.
  - S_WAIT: one idle cycle so `tmr_irq` deasserts. Next: S_TICK.
  - S_TICK: decrement all active channels. Next: S_IDLE.
  - S_STOP: one-cycle write, `tmr_address`=1, data 0x0008 (STOP). Next: S_HALT.
  - S_HALT: run=1 → S_START.
- Master outputs in every non-write state: `tmr_chipselect`=0, `tmr_write_n`=1, `tmr_address`=0, `tmr_writedata`=0.
- Tick rule per active channel, with count modulo 2^CNT_W, no underflow:
  - count>1: decrement.
  - count==1: set expired[ch], then:
    - periodic: count←reload.
    - else: count←0 and active←0.
- `irq` = irq_en & |(expired & MASK). Combinational from registers.

## Timing
- Reset values:
  - `readdata`=0, `irq`=0, all tmr_* outputs idle.
  - count, reload, active, expired, MASK and MODE all 0. CTRL=0x0001.
  - FSM in S_START.
- First timer write occurs in the first cycle after reset release.
- `readdata` latency: 1 cycle after a read with `chipselect`=1.
- Tick latency:
  - `tmr_irq` sampled high in S_IDLE at cycle t.
  - ACK write at t+1, counts update at end of t+3.
  - expired and `irq` visible at t+4.
- A CPU write to COUNT[ch] in the S_TICK cycle wins; that channel skips the tick.
- STATUS W1C in the same cycle as an expiry set: the set wins.
- run cleared mid-sequence (S_ACK/S_WAIT/S_TICK): the sequence completes, then S_IDLE→S_STOP.
- A `tmr_irq` arriving during S_HALT is ignored. The timer is restarted by S_START.
- Asynchronous reset mid-write drops the write immediately; the FSM restarts at S_START.

## Structure
- Shared package `configuration_timer_pkg`:
  - timer register addresses (STATUS=0, CONTROL=1).
  - control bit constants (ITO, CONT, START, STOP).
  - scheduler register offsets.
  - FSM state enum.
- Sub-module `configuration_timer_channel`, instantiated NUM_CH times. Holds count, reload, active and the expiry pulse. Inputs: load, load_value, tick, periodic.

## Test plan
- After reset: exactly one timer write, addr 1, data 0x0007; then idle. `readdata`=0, `irq`=0.
- COUNT0←3, MASK=1, CTRL=0x3, three `tmr_irq` pulses:
  - each pulse answered by an addr-0 write of 0 one cycle after it is sampled;
  - after the 3rd tick, STATUS=0x1 and `irq`=1 at t+4;
  - COUNT0 reads 0.
- MODE=0x2, COUNT1←2, five ticks: expired[1] set after ticks 2 and 4; COUNT1 reads 1 at the end.
- STATUS W1C issued in the same cycle that channel 0 expires: expired[0] stays 1.
- CTRL←0x0: timer write addr 1, data 0x0008; `tmr_irq` ignored. CTRL←0x1: addr 1, data 0x0007 rewritten.
- COUNT2 write in the S_TICK cycle: COUNT2 equals the written value (not decremented). Assert `reset_n` during the ACK write: outputs return to reset values in the same cycle.
